// File: rtl/simulador_adc_multicanal.sv
// ---------------------------------------------------------------------------
// simulador_adc_multicanal
//   Synthesisable model of a multi-channel serial ADC (MCP3204/MCP3208 style),
//   used as a slave stand-in for an FPGA ADC reader. Every register updates
//   on the falling edge of clk_adc.
//
// Ports:
//   clk_adc       in   serial clock from the master (falling edge active)
//   rst_n         in   synchronous active-low reset
//   cs            in   chip select, active-low; high forces IDLE
//   din_adc       in   command bit stream (start, SGL/DIFF, address MSB-first)
//   cargar        in   write strobe for the channel register bank
//   canal_carga   in   channel written by cargar
//   dato_carga    in   value written by cargar
//   datos_adc     out  registered serial conversion data
//   ocupado       out  high from start-bit detection until DONE
//   canal_actual  out  address latched by the last command
//   conversiones  out  completed conversion count (wraps)
// ---------------------------------------------------------------------------
module simulador_adc_multicanal #(
  parameter int DATA_BITS  = 12,
  parameter int CHANNELS   = 8,
  parameter int CH_BITS    = 3,
  parameter int LSB_REPEAT = 0,
  parameter int RAMP_MODE  = 0,
  parameter int RAMP_STEP  = 1
) (
  input  logic                 clk_adc,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 din_adc,
  input  logic                 cargar,
  input  logic [CH_BITS-1:0]   canal_carga,
  input  logic [DATA_BITS-1:0] dato_carga,
  output logic                 datos_adc,
  output logic                 ocupado,
  output logic [CH_BITS-1:0]   canal_actual,
  output logic [15:0]          conversiones
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CONFIG = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_NULL   = 3'd3;
  localparam logic [2:0] ST_MSB    = 3'd4;
  localparam logic [2:0] ST_LSB    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam int CNT_W = $clog2(DATA_BITS + CH_BITS + 2);
  localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(CH_BITS);
  localparam logic [CNT_W-1:0] MSB_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LSB_LAST = CNT_W'(DATA_BITS - 2);
  // Truncating the cast gives the step modulo 2**DATA_BITS.
  localparam logic [DATA_BITS-1:0] STEP = DATA_BITS'(RAMP_STEP);
  localparam logic RAMP_ON = (RAMP_MODE != 0);
  localparam logic LSB_ON  = (LSB_REPEAT != 0);

  logic [2:0]           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CH_BITS-1:0]   cmd;
  logic                 sgl_mode;
  logic [DATA_BITS-1:0] sr;
  logic [DATA_BITS-1:0] regs [CHANNELS];

  logic [CH_BITS:0]     cmd_full;
  logic [CH_BITS-1:0]   neg_idx;
  logic [DATA_BITS-1:0] pos_val;
  logic [DATA_BITS-1:0] neg_val;
  logic [DATA_BITS-1:0] result;
  logic                 ramp_en;

  // Complete command word including the bit sampled on this edge.
  assign cmd_full = {cmd, din_adc};
  // The differential partner is the other member of the pair.
  assign neg_idx  = canal_actual ^ CH_BITS'(1);

  // Conversion result for the latched command; out-of-range channels read 0.
  always_comb begin
    pos_val = '0;
    neg_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pos_val = (canal_actual == CH_BITS'(i)) ? regs[i] : pos_val;
      neg_val = (neg_idx == CH_BITS'(i)) ? regs[i] : neg_val;
    end
    if (sgl_mode) begin
      result = pos_val;
    end else if (pos_val > neg_val) begin
      result = pos_val - neg_val;
    end else begin
      result = '0;
    end
  end

  // Ramp fires on the D0 edge of a single-ended conversion only.
  assign ramp_en = RAMP_ON && !cs && (state == ST_MSB) &&
                   (bit_cnt == MSB_LAST) && sgl_mode;

  // Channel register bank: host load has priority over the ramp.
  always_ff @(negedge clk_adc) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rst_n) begin
        regs[i] <= '0;
      end else if (cargar && (canal_carga == CH_BITS'(i))) begin
        regs[i] <= dato_carga;
      end else if (ramp_en && (canal_actual == CH_BITS'(i))) begin
        regs[i] <= regs[i] + STEP;
      end else begin
        regs[i] <= regs[i];
      end
    end
  end

  // Serial protocol sequencer and registered outputs.
  always_ff @(negedge clk_adc) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      cmd          <= '0;
      sgl_mode     <= 1'b0;
      sr           <= '0;
      datos_adc    <= 1'b0;
      ocupado      <= 1'b0;
      canal_actual <= '0;
      conversiones <= 16'd0;
    end else if (cs) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      datos_adc <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          datos_adc <= 1'b0;
          bit_cnt   <= '0;
          if (din_adc) begin
            state   <= ST_CONFIG;
            ocupado <= 1'b1;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_CONFIG: begin
          datos_adc <= 1'b0;
          cmd       <= cmd_full[CH_BITS-1:0];
          if (bit_cnt == CFG_LAST) begin
            sgl_mode     <= cmd_full[CH_BITS];
            canal_actual <= cmd_full[CH_BITS-1:0];
            bit_cnt      <= '0;
            state        <= ST_SAMPLE;
          end else begin
            bit_cnt      <= bit_cnt + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          // Freeze the result: later loads or ramps cannot touch bits in flight.
          sr        <= result;
          datos_adc <= 1'b0;
          state     <= ST_NULL;
        end
        ST_NULL: begin
          datos_adc <= 1'b0;
          bit_cnt   <= '0;
          state     <= ST_MSB;
        end
        ST_MSB: begin
          // Rotate left so sr is back to its original value after DATA_BITS edges.
          datos_adc <= sr[DATA_BITS-1];
          sr        <= {sr[DATA_BITS-2:0], sr[DATA_BITS-1]};
          if (bit_cnt == MSB_LAST) begin
            conversiones <= conversiones + 16'd1;
            bit_cnt      <= '0;
            state        <= LSB_ON ? ST_LSB : ST_DONE;
          end else begin
            bit_cnt      <= bit_cnt + CNT_W'(1);
          end
        end
        ST_LSB: begin
          // sr[1] walks D1..D(DATA_BITS-1) as sr rotates right.
          datos_adc <= sr[1];
          sr        <= {sr[0], sr[DATA_BITS-1:1]};
          if (bit_cnt == LSB_LAST) begin
            bit_cnt <= '0;
            state   <= ST_DONE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          datos_adc <= 1'b0;
          ocupado   <= 1'b0;
          state     <= ST_DONE;
        end
        default: begin
          datos_adc <= 1'b0;
          ocupado   <= 1'b0;
          bit_cnt   <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simulador_adc_multicanal.sv
// ---------------------------------------------------------------------------
// tb_simulador_adc_multicanal
//   Two instances share the inputs: u0 with default parameters and u1 with
//   LSB_REPEAT=1, RAMP_MODE=1. A transaction-level model tracks the channel
//   values, the expected bit stream and the counters of each instance.
// ---------------------------------------------------------------------------
module tb_simulador_adc_multicanal;

  localparam int DB    = 12;
  localparam int NCH   = 8;
  localparam int CB    = 3;
  localparam int FIRST = CB + 5;          // edge of D(DB-1)
  localparam int LAST0 = FIRST + DB - 1;  // edge of D0
  localparam int LAST1 = LAST0 + DB - 1;  // last LSB-first bit
  localparam int MASK  = (1 << DB) - 1;

  logic          clk_adc = 1'b0;
  logic          rst_n, cs, din_adc, cargar;
  logic [CB-1:0] canal_carga;
  logic [DB-1:0] dato_carga;
  logic          dat0, ocu0, dat1, ocu1;
  logic [CB-1:0] can0, can1;
  logic [15:0]   conv0, conv1;

  int checks = 0;
  int errors = 0;
  int m_regs [2][NCH];
  int m_conv [2];
  int m_can;

  simulador_adc_multicanal #(.DATA_BITS(DB), .CHANNELS(NCH), .CH_BITS(CB),
    .LSB_REPEAT(0), .RAMP_MODE(0), .RAMP_STEP(1)) u0 (
    .clk_adc(clk_adc), .rst_n(rst_n), .cs(cs), .din_adc(din_adc),
    .cargar(cargar), .canal_carga(canal_carga), .dato_carga(dato_carga),
    .datos_adc(dat0), .ocupado(ocu0), .canal_actual(can0), .conversiones(conv0));

  simulador_adc_multicanal #(.DATA_BITS(DB), .CHANNELS(NCH), .CH_BITS(CB),
    .LSB_REPEAT(1), .RAMP_MODE(1), .RAMP_STEP(1)) u1 (
    .clk_adc(clk_adc), .rst_n(rst_n), .cs(cs), .din_adc(din_adc),
    .cargar(cargar), .canal_carga(canal_carga), .dato_carga(dato_carga),
    .datos_adc(dat1), .ocupado(ocu1), .canal_actual(can1), .conversiones(conv1));

  always #5 clk_adc = ~clk_adc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One falling edge with the given cs/din; outputs are sampled 1 time unit later.
  task automatic tick(input logic c, input logic d);
    cs = c;
    din_adc = d;
    @(negedge clk_adc);
    #1;
    cargar = 1'b0;
  endtask

  function automatic int rd(int u, int idx);
    return (idx < NCH) ? m_regs[u][idx] : 0;
  endfunction

  // Result from the datasheet rules: single-ended or clamped pair difference.
  function automatic int model_result(int u, int sgl, int addr);
    int p, inp, inn;
    if (sgl != 0) return rd(u, addr);
    p = addr / 2;
    if (addr % 2 == 0) begin
      inp = rd(u, 2 * p);
      inn = rd(u, 2 * p + 1);
    end else begin
      inp = rd(u, 2 * p + 1);
      inn = rd(u, 2 * p);
    end
    return (inp > inn) ? inp - inn : 0;
  endfunction

  function automatic logic exp_bit(int u, int k, int res);
    if (k >= FIRST && k <= LAST0) return 1'((res >> (LAST0 - k)) & 1);
    if (u == 1 && k > LAST0 && k <= LAST1) return 1'((res >> (k - LAST0)) & 1);
    return 1'b0;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_dat0"}, 32'(dat0), 32'd0);
    chk({tag, "_ocu0"}, 32'(ocu0), 32'd0);
    chk({tag, "_dat1"}, 32'(dat1), 32'd0);
    chk({tag, "_ocu1"}, 32'(ocu1), 32'd0);
    chk({tag, "_can0"}, 32'(can0), 32'(m_can));
    chk({tag, "_can1"}, 32'(can1), 32'(m_can));
    chk({tag, "_conv0"}, 32'(conv0), 32'(m_conv[0]));
    chk({tag, "_conv1"}, 32'(conv1), 32'(m_conv[1]));
  endtask

  // Host load while deselected.
  task automatic load(input int ch, input int val);
    cargar = 1'b1;
    canal_carga = CB'(ch);
    dato_carga = DB'(val);
    tick(1'b1, 1'b0);
    if (ch < NCH) begin
      m_regs[0][ch] = val & MASK;
      m_regs[1][ch] = val & MASK;
    end
    check_idle("load");
  endtask

  // Full transfer; abort_at>0 ends it at that edge with cs=1 (or rst_n=0 if use_rst).
  task automatic transfer(input string tag, input int sgl, input int addr, input int nlz,
                          input int abort_at, input int use_rst,
                          input int ld_at, input int ld_ch, input int ld_val);
    int res [2];
    logic d;
    for (int i = 0; i < nlz; i++) begin
      tick(1'b0, 1'b0);
      chk({tag, "_lz_ocu0"}, 32'(ocu0), 32'd0);
      chk({tag, "_lz_ocu1"}, 32'(ocu1), 32'd0);
    end
    res[0] = 0;
    res[1] = 0;
    for (int k = 1; k <= LAST1 + 2; k++) begin
      if (k == 1) d = 1'b1;
      else if (k == 2) d = 1'(sgl);
      else if (k <= 2 + CB) d = 1'((addr >> (CB - 1 - (k - 3))) & 1);
      else d = 1'($urandom_range(0, 1));
      if (k == FIRST - 2) begin
        res[0] = model_result(0, sgl, addr);
        res[1] = model_result(1, sgl, addr);
      end
      if (k == ld_at) begin
        cargar = 1'b1;
        canal_carga = CB'(ld_ch);
        dato_carga = DB'(ld_val);
      end
      if (k == abort_at) begin
        if (use_rst != 0) begin
          rst_n = 1'b0;
          tick(1'b0, d);
          rst_n = 1'b1;
          for (int u = 0; u < 2; u++) begin
            m_conv[u] = 0;
            for (int c = 0; c < NCH; c++) m_regs[u][c] = 0;
          end
          m_can = 0;
          check_idle({tag, "_rst"});
          tick(1'b1, 1'b0);
        end else begin
          tick(1'b1, d);
          if (k == ld_at && ld_ch < NCH) begin
            m_regs[0][ld_ch] = ld_val & MASK;
            m_regs[1][ld_ch] = ld_val & MASK;
          end
          check_idle({tag, "_abort"});
        end
        return;
      end
      tick(1'b0, d);
      if (k == 2 + CB) m_can = addr;
      if (k == LAST0) begin
        m_conv[0] = (m_conv[0] + 1) & 16'hFFFF;
        m_conv[1] = (m_conv[1] + 1) & 16'hFFFF;
        if (sgl != 0 && addr < NCH) m_regs[1][addr] = (m_regs[1][addr] + 1) & MASK;
      end
      if (k == ld_at && ld_ch < NCH) begin
        m_regs[0][ld_ch] = ld_val & MASK;
        m_regs[1][ld_ch] = ld_val & MASK;
      end
      chk($sformatf("%s_e%0d_dat0", tag, k), 32'(dat0), 32'(exp_bit(0, k, res[0])));
      chk($sformatf("%s_e%0d_dat1", tag, k), 32'(dat1), 32'(exp_bit(1, k, res[1])));
      chk($sformatf("%s_e%0d_ocu0", tag, k), 32'(ocu0), 32'(k <= LAST0));
      chk($sformatf("%s_e%0d_ocu1", tag, k), 32'(ocu1), 32'(k <= LAST1));
      if (k >= 2 + CB) begin
        chk($sformatf("%s_e%0d_can0", tag, k), 32'(can0), 32'(m_can));
        chk($sformatf("%s_e%0d_can1", tag, k), 32'(can1), 32'(m_can));
      end
    end
    tick(1'b1, 1'b0);
    check_idle({tag, "_end"});
  endtask

  initial begin
    int sgl, addr, nlz, ld_at;
    for (int u = 0; u < 2; u++) begin
      m_conv[u] = 0;
      for (int c = 0; c < NCH; c++) m_regs[u][c] = 0;
    end
    m_can = 0;
    rst_n = 1'b0;
    cs = 1'b1;
    din_adc = 1'b0;
    cargar = 1'b0;
    canal_carga = '0;
    dato_carga = '0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check_idle("reset");
    rst_n = 1'b1;

    // Single-ended channel 5, leading zeros before the start bit.
    load(5, 12'hA5C);
    transfer("t1_ch5", 1, 5, 2, 0, 0, 0, 0, 0);

    // LSB-first repeat on channel 2.
    load(2, 12'h3C1);
    transfer("t2_ch2", 1, 2, 0, 0, 0, 0, 0, 0);

    // Differential pair 0/1, both orientations (second clamps to 0).
    load(0, 12'h800);
    load(1, 12'h300);
    transfer("t3_diff0", 0, 0, 0, 0, 0, 0, 0, 0);
    transfer("t3_diff1", 0, 1, 0, 0, 0, 0, 0, 0);

    // Ramp wrap on channel 7.
    load(7, 12'hFFF);
    transfer("t4_ramp_a", 1, 7, 0, 0, 0, 0, 0, 0);
    transfer("t4_ramp_b", 1, 7, 0, 0, 0, 0, 0, 0);

    // Abort with cs at edge 12, then a clean transfer.
    transfer("t5_abort", 1, 2, 1, 12, 0, 0, 0, 0);
    transfer("t5_after", 1, 2, 0, 0, 0, 0, 0, 0);

    // Load during shifting is not seen until the next conversion.
    load(3, 12'h0F0);
    transfer("t6_ld_mid", 1, 3, 0, 0, 0, 10, 3, 12'h111);
    transfer("t6_ld_next", 1, 3, 0, 0, 0, 0, 0, 0);

    // Load and ramp on the same channel and edge: load wins.
    transfer("t6_ld_ramp", 1, 3, 0, 0, 0, LAST0, 3, 12'h222);
    transfer("t6_ld_ramp_chk", 1, 3, 0, 0, 0, 0, 0, 0);

    // Randomised transfers with random loads.
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 1) == 1) load($urandom_range(0, NCH - 1), $urandom_range(0, MASK));
      sgl   = $urandom_range(0, 1);
      addr  = $urandom_range(0, NCH - 1);
      nlz   = $urandom_range(0, 3);
      ld_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, LAST1) : 0;
      transfer($sformatf("rnd%0d", r), sgl, addr, nlz, 0, 0, ld_at,
               $urandom_range(0, NCH - 1), $urandom_range(0, MASK));
    end

    // Reset in the middle of a transfer clears everything.
    load(5, 12'h5A5);
    transfer("t6_rst", 1, 5, 0, 14, 1, 0, 0, 0);
    transfer("t6_post_rst", 1, 5, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
